gamma_lut_prog: RTL and testbench
=================================

Name: gamma_lut_prog

Overview:
Programmable, double-buffered gamma lookup table for one 6-bit colour channel in the AHBISPSYS pixel path. Firmware writes a 64-entry curve into a shadow bank through a sequential config port. On request, the shadow bank becomes active at the next frame boundary. Pixels stream through the active bank with a valid/ready handshake and 1-cycle latency. The block bypasses pixels unchanged until the first curve is committed.

Parameters:
DW, 6, pixel and table-entry width
AW, 6, table address width; depth = 2**AW entries (AW equals DW, since the pixel value is the address)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  pulse; sets the write pointer to 0 and clears cfg_full_o
cfg_wr_en  in  1  write cfg_wr_data to shadow[wptr]; wptr increments
cfg_wr_data  in  DW  table entry
cfg_full_o  out  1  all 2**AW entries written since cfg_start
cfg_commit  in  1  pulse; request bank swap at next frame start
cfg_pending_o  out  1  commit requested, swap not yet done
frame_start  in  1  pulse, first cycle of a frame
pix_valid_i  in  1  input pixel valid
pix_data_i  in  DW  input pixel (table address)
pix_ready_o  out  1  block accepts input this cycle
pix_valid_o  out  1  output pixel valid
pix_data_o  out  DW  corrected pixel
pix_ready_i  in  1  downstream accepts output

Behaviour:
- Reset values: cfg_full_o=0, cfg_pending_o=0, pix_valid_o=0, pix_data_o=0, wptr=0, active_sel=0, loaded=0. RAM contents are not reset.
- Storage: two banks of 2**AW x DW. The active bank is selected by active_sel; the shadow bank is the other one.
- Write pointer:
  - cfg_wr_en with cfg_full_o=0 writes shadow[wptr] and increments wptr.
  - When the write to the last address (2**AW-1) completes, cfg_full_o is set and the pointer does not wrap.
  - Writes while cfg_full_o=1 are ignored.
  - cfg_start has priority over cfg_wr_en in the same cycle: wptr becomes 0 and no write occurs.
- Commit state machine, states IDLE -> PEND -> IDLE:
  - cfg_commit is accepted only when cfg_full_o=1; otherwise it is ignored. Acceptance moves IDLE->PEND and sets cfg_pending_o=1.
  - In PEND, frame_start toggles active_sel and sets loaded=1, clears cfg_full_o, resets wptr to 0, clears cfg_pending_o, and returns to IDLE.
  - If cfg_commit and frame_start occur in the same cycle, the swap waits for the next frame_start.
  - While in PEND, cfg_start and cfg_wr_en are ignored so the shadow bank stays frozen.
- Pixel pipeline:
  - One output register. pix_ready_o = !pix_valid_o || pix_ready_i.
  - Handshake: a transfer occurs when pix_valid_i && pix_ready_o. On transfer, the next cycle gives pix_valid_o=1 and pix_data_o = loaded ? active[pix_data_i] : pix_data_i.
  - If pix_ready_i=1 and no new input arrives, pix_valid_o clears.
  - While stalled (pix_valid_o && !pix_ready_i), pix_data_o is held stable.
  - Lookup uses active_sel as sampled on the acceptance cycle, so a swap never alters an in-flight pixel.
- Reset mid-frame: asynchronous reset drops pix_valid_o immediately and aborts any pending commit. The block returns to bypass (loaded=0).

Optional Feature:
GAMMA_LUT_READBACK_EN adds ports rb_en (in, 1), rb_addr (in, AW), rb_data_o (out, DW) and rb_valid_o (out, 1).
- Defined: one cycle after rb_en, rb_valid_o=1 and rb_data_o = active[rb_addr]. The read is independent of the pixel path; the banks need a second read port.
- Undefined: these ports are absent, and each bank needs one read and one write port only.

Decomposition:
- Shared package gamma_pkg holds:
  - the localparams for DW and AW and the depth;
  - the commit-state encoding (IDLE=0, PEND=1);
  - the identity-curve helper constant used by the bench.
- One natural sub-module: gamma_lut_bank, a 2**AW x DW RAM with a synchronous write port and a registered read. It is instantiated twice; the top owns the bank select.

Test Plan:
1. Pixel 37 presented, no curve ever loaded -> pix_data_o=37 one cycle later; pix_valid_o=1.
2. cfg_start, write 64 entries of 63-i, cfg_commit, frame_start, then pixel 10 -> output 53. cfg_full_o=0 and cfg_pending_o=0 after the swap.
3. After 30 writes, cfg_commit is ignored (cfg_pending_o stays 0). A 70-write burst sets cfg_full_o after the 64th write; writes 65-70 leave shadow[0..63] unchanged.
4. pix_ready_i held 0 for 5 cycles with pixel 5 in flight -> pix_data_o stable for those cycles and pix_ready_o=0. Release -> pixels 5, 6, 7 delivered in order with no loss or duplication.
5. cfg_commit and frame_start in the same cycle -> active curve unchanged (old mapping holds). The next frame_start swaps, and pixel 0 maps to the new entry 0.
6. rst_n asserted while cfg_pending_o=1 and pix_valid_o=1 -> both outputs 0 immediately. After release, pixel 20 outputs 20 (bypass).

Source files
------------

// File: rtl/gamma_pkg.sv
// gamma_pkg: shared definitions for the programmable gamma LUT.
//   GAMMA_DW / GAMMA_AW / GAMMA_DEPTH : pixel width, table address width, depth
//   commit_state_e                    : bank-swap commit state encoding
//   gamma_identity()                  : identity curve (bypass mapping)
package gamma_pkg;

  localparam int unsigned GAMMA_DW    = 6;
  localparam int unsigned GAMMA_AW    = 6;
  localparam int unsigned GAMMA_DEPTH = 2 ** GAMMA_AW;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } commit_state_e;

  function automatic logic [GAMMA_DW-1:0] gamma_identity(input int unsigned idx);
    return GAMMA_DW'(idx);
  endfunction

endpackage

// File: rtl/gamma_lut_bank.sv
// gamma_lut_bank: 2**AW x DW table RAM, synchronous write, registered read.
// Contents are not reset; only the read register is.
// Optional macro GAMMA_LUT_READBACK_EN adds a second registered read port.
// Ports:
//   clk, rst_n            clock, async active-low reset (read registers)
//   we_i/waddr_i/wdata_i  write port
//   re_i/raddr_i/rdata_o  read port; rdata_o updates only when re_i=1
//   rb_re_i/rb_addr_i/rb_data_o  readback port (GAMMA_LUT_READBACK_EN)
module gamma_lut_bank #(
  parameter int unsigned DW = 6,
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
`ifdef GAMMA_LUT_READBACK_EN
  ,
  input  logic          rb_re_i,
  input  logic [AW-1:0] rb_addr_i,
  output logic [DW-1:0] rb_data_o
`endif
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read register holds when not enabled, which keeps a stalled pixel stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

`ifdef GAMMA_LUT_READBACK_EN
  logic [DW-1:0] rb_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rb_data_q <= '0;
    else if (rb_re_i) rb_data_q <= mem_q[rb_addr_i];
  end

  assign rb_data_o = rb_data_q;
`endif

endmodule

// File: rtl/gamma_lut_prog.sv
// gamma_lut_prog: programmable double-buffered gamma LUT for one colour channel.
// Firmware fills the shadow bank through cfg_wr_*, requests a swap with
// cfg_commit, and the swap happens on the next frame_start. Pixels pass
// unchanged until the first curve is committed. 1-cycle valid/ready pipeline.
// Optional macro GAMMA_LUT_READBACK_EN adds rb_en/rb_addr/rb_data_o/rb_valid_o
// reading the active bank one cycle after rb_en.
// Ports:
//   cfg_start/cfg_wr_en/cfg_wr_data/cfg_full_o    shadow-bank write port
//   cfg_commit/cfg_pending_o/frame_start          bank swap control
//   pix_valid_i/pix_data_i/pix_ready_o            input pixel stream
//   pix_valid_o/pix_data_o/pix_ready_i            output pixel stream
module gamma_lut_prog
  import gamma_pkg::*;
#(
  parameter int unsigned DW = GAMMA_DW,
  parameter int unsigned AW = GAMMA_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_start,
  input  logic          cfg_wr_en,
  input  logic [DW-1:0] cfg_wr_data,
  output logic          cfg_full_o,
  input  logic          cfg_commit,
  output logic          cfg_pending_o,
  input  logic          frame_start,
  input  logic          pix_valid_i,
  input  logic [DW-1:0] pix_data_i,
  output logic          pix_ready_o,
  output logic          pix_valid_o,
  output logic [DW-1:0] pix_data_o,
  input  logic          pix_ready_i
`ifdef GAMMA_LUT_READBACK_EN
  ,
  input  logic          rb_en,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data_o,
  output logic          rb_valid_o
`endif
);

  commit_state_e state_q, state_d;
  logic [AW-1:0] wptr_q;
  logic          full_q;
  logic          sel_q;      // active bank select
  logic          loaded_q;   // a curve has been committed
  logic          valid_q;
  logic          rd_sel_q;   // bank select captured with the pixel
  logic          rd_lut_q;   // loaded captured with the pixel
  logic [DW-1:0] byp_q;
  logic          swap, wr_fire, accept;
  logic [DW-1:0] rdata0, rdata1;

  // ---- commit FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    swap    = 1'b0;
    wr_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        wr_fire = !cfg_start && cfg_wr_en && !full_q;
        if (cfg_commit && full_q) state_d = PEND;
      end
      PEND: begin
        if (frame_start) begin
          swap    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_pending_o = (state_q == PEND);
  assign cfg_full_o    = full_q;

  // ---- write pointer, bank select ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      full_q   <= 1'b0;
      sel_q    <= 1'b0;
      loaded_q <= 1'b0;
    end else if (swap) begin
      sel_q    <= ~sel_q;
      loaded_q <= 1'b1;
      full_q   <= 1'b0;
      wptr_q   <= '0;
    end else if (state_q == IDLE) begin
      if (cfg_start) begin
        wptr_q <= '0;
        full_q <= 1'b0;
      end else if (wr_fire) begin
        // Pointer parks on the last address instead of wrapping.
        if (wptr_q == AW'(2**AW - 1)) full_q <= 1'b1;
        else                          wptr_q <= wptr_q + 1'b1;
      end
    end
  end

  // ---- pixel pipeline ----
  assign accept      = pix_valid_i && pix_ready_o;
  assign pix_ready_o = !valid_q || pix_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      rd_sel_q <= 1'b0;
      rd_lut_q <= 1'b0;
      byp_q    <= '0;
    end else begin
      if (accept) begin
        valid_q  <= 1'b1;
        rd_sel_q <= sel_q;
        rd_lut_q <= loaded_q;
        byp_q    <= pix_data_i;
      end else if (pix_ready_i) begin
        valid_q  <= 1'b0;
      end
    end
  end

  // The bank read registers form the output stage; they and the captured
  // select/bypass registers all update only on accept, so a stall holds data.
  assign pix_valid_o = valid_q;
  assign pix_data_o  = !rd_lut_q ? byp_q : (rd_sel_q ? rdata1 : rdata0);

`ifdef GAMMA_LUT_READBACK_EN
  logic          rb_valid_q, rb_sel_q;
  logic [DW-1:0] rb0, rb1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_valid_q <= 1'b0;
      rb_sel_q   <= 1'b0;
    end else begin
      rb_valid_q <= rb_en;
      if (rb_en) rb_sel_q <= sel_q;
    end
  end

  assign rb_valid_o = rb_valid_q;
  assign rb_data_o  = rb_sel_q ? rb1 : rb0;
`endif

  // Shadow bank is the one not selected.
  gamma_lut_bank #(.DW(DW), .AW(AW)) u_bank0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (wr_fire && sel_q),
    .waddr_i  (wptr_q),
    .wdata_i  (cfg_wr_data),
    .re_i     (accept),
    .raddr_i  (pix_data_i[AW-1:0]),
    .rdata_o  (rdata0)
`ifdef GAMMA_LUT_READBACK_EN
    ,
    .rb_re_i  (rb_en),
    .rb_addr_i(rb_addr),
    .rb_data_o(rb0)
`endif
  );

  gamma_lut_bank #(.DW(DW), .AW(AW)) u_bank1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (wr_fire && !sel_q),
    .waddr_i  (wptr_q),
    .wdata_i  (cfg_wr_data),
    .re_i     (accept),
    .raddr_i  (pix_data_i[AW-1:0]),
    .rdata_o  (rdata1)
`ifdef GAMMA_LUT_READBACK_EN
    ,
    .rb_re_i  (rb_en),
    .rb_addr_i(rb_addr),
    .rb_data_o(rb1)
`endif
  );

endmodule

// File: tb/tb_gamma_lut_prog.sv
// tb_gamma_lut_prog: directed self-checking bench for gamma_lut_prog.
module tb_gamma_lut_prog;
  import gamma_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_start, cfg_wr_en, cfg_commit, frame_start;
  logic [5:0] cfg_wr_data;
  logic       cfg_full_o, cfg_pending_o;
  logic       pix_valid_i, pix_ready_i, pix_ready_o, pix_valid_o;
  logic [5:0] pix_data_i, pix_data_o;
`ifdef GAMMA_LUT_READBACK_EN
  logic       rb_en, rb_valid_o;
  logic [5:0] rb_addr, rb_data_o;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  gamma_lut_prog #(.DW(6), .AW(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_start    (cfg_start),
    .cfg_wr_en    (cfg_wr_en),
    .cfg_wr_data  (cfg_wr_data),
    .cfg_full_o   (cfg_full_o),
    .cfg_commit   (cfg_commit),
    .cfg_pending_o(cfg_pending_o),
    .frame_start  (frame_start),
    .pix_valid_i  (pix_valid_i),
    .pix_data_i   (pix_data_i),
    .pix_ready_o  (pix_ready_o),
    .pix_valid_o  (pix_valid_o),
    .pix_data_o   (pix_data_o),
    .pix_ready_i  (pix_ready_i)
`ifdef GAMMA_LUT_READBACK_EN
    ,
    .rb_en        (rb_en),
    .rb_addr      (rb_addr),
    .rb_data_o    (rb_data_o),
    .rb_valid_o   (rb_valid_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Test curves written to the shadow bank.
  function automatic logic [5:0] curve(input int unsigned kind, input int unsigned i);
    case (kind)
      0:       return 6'(63 - i);
      1:       return 6'(i * 5);
      2:       return 6'(i + 7);
      default: return 6'(i ^ 21);
    endcase
  endfunction

  task automatic write_curve(input int unsigned kind, input int unsigned count);
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    for (int unsigned i = 0; i < count; i++) begin
      cfg_wr_en   = 1'b1;
      cfg_wr_data = (i < 64) ? curve(kind, i) : 6'd42;
      tick();
      if (i == 62) check("full_before_last", cfg_full_o, 0);
      if (i == 63) check("full_after_64", cfg_full_o, 1);
    end
    cfg_wr_en = 1'b0;
  endtask

  task automatic pixel(input string tag, input logic [5:0] pin, input logic [5:0] exp);
    pix_valid_i = 1'b1; pix_data_i = pin; pix_ready_i = 1'b1;
    tick();
    pix_valid_i = 1'b0;
    check({tag, "_valid"}, pix_valid_o, 1);
    check({tag, "_data"}, pix_data_o, exp);
    tick();
  endtask

  task automatic commit_and_swap();
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    check("pending_set", cfg_pending_o, 1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("pending_clr", cfg_pending_o, 0);
    check("full_clr", cfg_full_o, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_start = 0; cfg_wr_en = 0; cfg_wr_data = '0; cfg_commit = 0; frame_start = 0;
    pix_valid_i = 0; pix_data_i = '0; pix_ready_i = 1'b1;
`ifdef GAMMA_LUT_READBACK_EN
    rb_en = 0; rb_addr = '0;
`endif
    #12;
    check("rst_full", cfg_full_o, 0);
    check("rst_pending", cfg_pending_o, 0);
    check("rst_valid", pix_valid_o, 0);
    check("rst_data", pix_data_o, 0);
    rst_n = 1'b1;
    tick();

    // 1: bypass before any curve
    pixel("byp37", 6'd37, gamma_identity(37));
    check("byp_drain", pix_valid_o, 0);

    // 2: inverse curve
    write_curve(0, 64);
    commit_and_swap();
    pixel("inv10", 6'd10, 6'd53);
    pixel("inv63", 6'd63, 6'd0);

    // 3: commit ignored when not full; 70-write burst
    write_curve(3, 30);
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    check("commit_ignored", cfg_pending_o, 0);
    write_curve(1, 70);
    check("full_after_70", cfg_full_o, 1);
    commit_and_swap();
    pixel("x5_0", 6'd0, 6'd0);
    pixel("x5_1", 6'd1, 6'd5);
    pixel("x5_63", 6'd63, 6'd59);

`ifdef GAMMA_LUT_READBACK_EN
    rb_en = 1'b1; rb_addr = 6'd9; tick(); rb_en = 1'b0;
    check("rb_valid", rb_valid_o, 1);
    check("rb_data", rb_data_o, 45);
`endif

    // 4: stall with pixel 5 in flight, then 6 and 7
    pix_ready_i = 1'b0; pix_valid_i = 1'b1; pix_data_i = 6'd5;
    tick();
    pix_data_i = 6'd6;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", pix_valid_o, 1);
      check("stall_data", pix_data_o, 25);
      check("stall_ready", pix_ready_o, 0);
      tick();
    end
    pix_ready_i = 1'b1;
    #1;
    check("rel_ready", pix_ready_o, 1);
    check("rel_data5", pix_data_o, 25);
    tick();
    pix_data_i = 6'd7;
    check("rel_data6", pix_data_o, 30);
    tick();
    pix_valid_i = 1'b0;
    check("rel_data7", pix_data_o, 35);
    check("rel_valid7", pix_valid_o, 1);
    tick();
    check("rel_drain", pix_valid_o, 0);

    // 5: commit coincident with frame_start waits for next frame
    write_curve(2, 64);
    cfg_commit = 1'b1; frame_start = 1'b1; tick();
    cfg_commit = 1'b0; frame_start = 1'b0;
    check("coinc_pending", cfg_pending_o, 1);
    pixel("old3", 6'd3, 6'd15);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("coinc_swapped", cfg_pending_o, 0);
    pixel("new0", 6'd0, 6'd7);

    // 6: async reset with commit pending and a stalled pixel
    write_curve(0, 64);
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    pix_ready_i = 1'b0; pix_valid_i = 1'b1; pix_data_i = 6'd9;
    tick();
    pix_valid_i = 1'b0;
    check("pre_rst_pending", cfg_pending_o, 1);
    check("pre_rst_valid", pix_valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pending", cfg_pending_o, 0);
    check("mid_rst_valid", pix_valid_o, 0);
    check("mid_rst_full", cfg_full_o, 0);
    #3 rst_n = 1'b1;
    pix_ready_i = 1'b1;
    tick();
    pixel("post_rst20", 6'd20, gamma_identity(20));
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    pixel("post_rst_fs", 6'd20, 6'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
